ip_codma_bus_arbiter: RTL

IP_CODMA_BUS_ARBITER -- requirements
Module: ip_codma_bus_arbiter

---
 rtl/ip_codma_bus_arbiter_if.sv | 29 ++
 rtl/ip_codma_bus_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/ip_codma_bus_arbiter_if.sv
// Handshake and bus signals between the read/write DMA machines, the system bus and the arbiter.
interface ip_codma_bus_arbiter_if;
    logic       rd_req_i;
    logic [3:0] rd_size_i;
    logic       rd_grant_o;
    logic       wr_req_i;
    logic [3:0] wr_size_i;
    logic       wr_grant_o;
    logic       bus_req_o;
    logic       bus_grant_i;
    logic       bus_beat_i;
    logic       bus_error_i;
    logic       owner_o;
    logic       error_o;

    // Arbiter side.
    modport slave (
        input  rd_req_i, rd_size_i, wr_req_i, wr_size_i,
        input  bus_grant_i, bus_beat_i, bus_error_i,
        output rd_grant_o, wr_grant_o, bus_req_o, owner_o, error_o
    );

    // Requester / bus side.
    modport master (
        output rd_req_i, rd_size_i, wr_req_i, wr_size_i,
        output bus_grant_i, bus_beat_i, bus_error_i,
        input  rd_grant_o, wr_grant_o, bus_req_o, owner_o, error_o
    );
endinterface

// File: rtl/ip_codma_bus_arbiter.sv
// Round-robin arbiter sharing one system bus between the DMA read and write machines.
// All outputs are registered, decoded from the next state.
module ip_codma_bus_arbiter #(
    parameter int unsigned GRANT_TIMEOUT = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    ip_codma_bus_arbiter_if.slave        bus
);

    typedef enum logic [2:0] {ArbIdle, ArbReq, ArbXfer, ArbDone, ArbErr} arb_state_e;

    arb_state_e state_q, state_d;
    logic       sel_q, sel_d;       // 0 read, 1 write
    logic [2:0] len_q, len_d;       // decoded beats, 0 = illegal size
    logic [2:0] beat_q, beat_d;
    logic [7:0] tmo_q, tmo_d;
    logic       owner_q, owner_d;
    logic       rd_grant_q, rd_grant_d;
    logic       wr_grant_q, wr_grant_d;
    logic       bus_req_q, bus_req_d;
    logic       error_q, error_d;

    function automatic logic [2:0] decode_len(input logic [3:0] size);
        case (size)
            4'd3:    decode_len = 3'd1;
            4'd8:    decode_len = 3'd3;
            4'd9:    decode_len = 3'd4;
            default: decode_len = 3'd0;
        endcase
    endfunction

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ArbIdle;
            sel_q      <= 1'b0;
            len_q      <= 3'd0;
            beat_q     <= 3'd0;
            tmo_q      <= 8'd0;
            owner_q    <= 1'b1;
            rd_grant_q <= 1'b0;
            wr_grant_q <= 1'b0;
            bus_req_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            tmo_q      <= tmo_d;
            owner_q    <= owner_d;
            rd_grant_q <= rd_grant_d;
            wr_grant_q <= wr_grant_d;
            bus_req_q  <= bus_req_d;
            error_q    <= error_d;
        end
    end

    // Next-state logic: selection, grant wait with timeout, beat counting.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        len_d   = len_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            ArbIdle: begin
                if (bus.rd_req_i || bus.wr_req_i) begin
                    // On a tie the master that did not own the bus last wins.
                    if (bus.rd_req_i && bus.wr_req_i) sel_d = ~owner_q;
                    else                              sel_d = bus.wr_req_i;
                    len_d   = decode_len(sel_d ? bus.wr_size_i : bus.rd_size_i);
                    beat_d  = 3'd0;
                    tmo_d   = 8'd0;
                    state_d = (len_d != 3'd0) ? ArbReq : ArbErr;
                end
            end
            ArbReq: begin
                if (bus.bus_error_i) begin
                    state_d = ArbErr;
                end else if (bus.bus_grant_i) begin
                    state_d = ArbXfer;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                    if (tmo_d == 8'(GRANT_TIMEOUT)) state_d = ArbErr;
                end
            end
            ArbXfer: begin
                if (bus.bus_error_i) begin
                    state_d = ArbErr;
                end else if (bus.bus_beat_i) begin
                    beat_d = beat_q + 3'd1;
                    if (beat_d == len_q) state_d = ArbDone;
                end
            end
            ArbDone: state_d = ArbIdle;
            ArbErr:  state_d = ArbIdle;
            default: state_d = ArbIdle;
        endcase
    end

    // Output decode from the next state so every output comes straight from a flop.
    always_comb begin
        rd_grant_d = (state_d == ArbXfer) && !sel_d;
        wr_grant_d = (state_d == ArbXfer) && sel_d;
        bus_req_d  = (state_d == ArbReq) || (state_d == ArbXfer);
        error_d    = (state_d == ArbErr);
        owner_d    = ((state_d == ArbDone) || (state_d == ArbErr)) ? sel_d : owner_q;
    end

    assign bus.rd_grant_o = rd_grant_q;
    assign bus.wr_grant_o = wr_grant_q;
    assign bus.bus_req_o  = bus_req_q;
    assign bus.error_o    = error_q;
    assign bus.owner_o    = owner_q;

endmodule
